// File: rtl/motor_pkg.sv
// Shared motor-control definitions: capture FSM state encodings and the
// 3-bit speed-state codes used by the motor FSM, display decoders and capture.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } cap_state_t;

    localparam logic [2:0] PWM_STATE_0   = 3'd0;
    localparam logic [2:0] PWM_STATE_25  = 3'd1;
    localparam logic [2:0] PWM_STATE_50  = 3'd2;
    localparam logic [2:0] PWM_STATE_75  = 3'd3;
    localparam logic [2:0] PWM_STATE_100 = 3'd4;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a third flop for
// single-cycle rise/fall strobes on the synchronized signal.
module pwm_sync_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized value
    logic [2:0] sync_reg;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], i_din};
        end
    end

    assign o_level = sync_reg[1];
    assign o_rise  = sync_reg[1] & ~sync_reg[2];
    assign o_fall  = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures high time and period of a PWM line, quantizes the duty to the
// motor speed-state code and flags a line with no rising edge for TIMEOUT cycles.
module pwm_duty_capture
    import motor_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 2048
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pwm,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic [CNT_W-1:0] o_period_cnt,
    output logic             o_valid,
    output logic [2:0]       o_pwm_state,
    output logic             o_timeout
);

    localparam int               IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_HIT = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam int               Q_W      = CNT_W + 3;

    logic s_pwm;
    logic s_rise;
    logic s_fall;

    pwm_sync_edge u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_din   (i_pwm),
        .o_level (s_pwm),
        .o_rise  (s_rise),
        .o_fall  (s_fall)
    );

    cap_state_t        state_reg;
    logic [CNT_W-1:0]  hi_cnt_reg;
    logic [CNT_W-1:0]  lo_cnt_reg;
    logic [IDLE_W-1:0] idle_cnt_reg;

    logic [CNT_W-1:0] hi_inc;
    logic [CNT_W-1:0] lo_inc;
    logic [CNT_W:0]   period_sum;
    logic [CNT_W-1:0] period_sat;
    logic             stuck_hit;

    assign hi_inc     = (hi_cnt_reg == CNT_MAX) ? hi_cnt_reg : hi_cnt_reg + CNT_ONE;
    assign lo_inc     = (lo_cnt_reg == CNT_MAX) ? lo_cnt_reg : lo_cnt_reg + CNT_ONE;
    assign period_sum = {1'b0, hi_cnt_reg} + {1'b0, lo_cnt_reg};
    assign period_sat = period_sum[CNT_W] ? CNT_MAX : period_sum[CNT_W-1:0];

    // Fires on the edge where idle_cnt becomes TIMEOUT, so the flag rises
    // exactly TIMEOUT cycles after the last rise was seen.
    assign stuck_hit = !s_rise && (state_reg != ST_STUCK) && (idle_cnt_reg == IDLE_HIT);

    // Quantizer: duty*8 compared against odd multiples of the period gives
    // round-to-nearest quarter with ties rounding up.
    logic [Q_W-1:0] h8;
    logic [Q_W-1:0] p_ext;
    logic [3:0]     ge;
    logic [2:0]     quant_next;

    assign h8    = {hi_cnt_reg, 3'b000};
    assign p_ext = {3'b000, period_sat};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_thresh
            logic [Q_W-1:0] thr;
            assign thr    = p_ext * Q_W'(2 * gi + 1);
            assign ge[gi] = (h8 >= thr);
        end
    endgenerate

    always_comb begin
        quant_next = PWM_STATE_0;
        for (int k = 0; k < 4; k++) begin
            quant_next = quant_next + {2'b00, ge[k]};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg    <= ST_IDLE;
            hi_cnt_reg   <= '0;
            lo_cnt_reg   <= '0;
            idle_cnt_reg <= '0;
            o_high_cnt   <= '0;
            o_period_cnt <= '0;
            o_valid      <= 1'b0;
            o_pwm_state  <= PWM_STATE_0;
            o_timeout    <= 1'b0;
        end else begin
            o_valid <= 1'b0;

            if (s_rise) begin
                idle_cnt_reg <= '0;
            end else if (idle_cnt_reg != IDLE_MAX) begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end

            if (stuck_hit) begin
                state_reg    <= ST_STUCK;
                hi_cnt_reg   <= '0;
                lo_cnt_reg   <= '0;
                o_timeout    <= 1'b1;
                o_high_cnt   <= '0;
                o_period_cnt <= '0;
                o_pwm_state  <= s_pwm ? PWM_STATE_100 : PWM_STATE_0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        hi_cnt_reg <= '0;
                        lo_cnt_reg <= '0;
                        if (s_rise) begin
                            state_reg  <= ST_HIGH;
                            hi_cnt_reg <= CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (s_fall) begin
                            state_reg  <= ST_LOW;
                            lo_cnt_reg <= CNT_ONE;
                        end else if (s_pwm) begin
                            hi_cnt_reg <= hi_inc;
                        end
                    end
                    ST_LOW: begin
                        if (s_rise) begin
                            o_high_cnt   <= hi_cnt_reg;
                            o_period_cnt <= period_sat;
                            o_pwm_state  <= quant_next;
                            o_valid      <= 1'b1;
                            state_reg    <= ST_HIGH;
                            hi_cnt_reg   <= CNT_ONE;
                            lo_cnt_reg   <= '0;
                        end else begin
                            lo_cnt_reg <= lo_inc;
                        end
                    end
                    ST_STUCK: begin
                        o_pwm_state <= s_pwm ? PWM_STATE_100 : PWM_STATE_0;
                        if (s_rise) begin
                            state_reg  <= ST_HIGH;
                            hi_cnt_reg <= CNT_ONE;
                            lo_cnt_reg <= '0;
                            o_timeout  <= 1'b0;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture: a 16-bit instance for the main
// function and timeout, and an 8-bit instance for counter saturation.
module tb_pwm_duty_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pwm = 1'b0;
    logic        pwm8 = 1'b0;

    logic [15:0] high_cnt, period_cnt;
    logic        valid, timeout;
    logic [2:0]  pwm_state;
    logic [7:0]  high_cnt8, period_cnt8;
    logic        valid8, timeout8;
    logic [2:0]  pwm_state8;

    always #5 clk = ~clk;

    pwm_duty_capture #(.CNT_W(16), .TIMEOUT(2048)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_pwm        (pwm),
        .o_high_cnt   (high_cnt),
        .o_period_cnt (period_cnt),
        .o_valid      (valid),
        .o_pwm_state  (pwm_state),
        .o_timeout    (timeout)
    );

    pwm_duty_capture #(.CNT_W(8), .TIMEOUT(2048)) dut8 (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_pwm        (pwm8),
        .o_high_cnt   (high_cnt8),
        .o_period_cnt (period_cnt8),
        .o_valid      (valid8),
        .o_pwm_state  (pwm_state8),
        .o_timeout    (timeout8)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("check %s: got %0d ok", tag, got);
        end
    endtask

    // Capture every measurement pulse
    int          vcnt = 0;
    int          vcnt8 = 0;
    logic [15:0] last_hi = '0, last_per = '0;
    logic [2:0]  last_st = '0;
    logic [7:0]  last_hi8 = '0, last_per8 = '0;
    logic [2:0]  last_st8 = '0;

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            last_hi  = high_cnt;
            last_per = period_cnt;
            last_st  = pwm_state;
        end
        if (valid8) begin
            vcnt8++;
            last_hi8  = high_cnt8;
            last_per8 = period_cnt8;
            last_st8  = pwm_state8;
        end
    end

    task automatic run_pwm(input bit sel, input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) pwm8 = 1'b1; else pwm = 1'b1;
            repeat (hi) @(negedge clk);
            if (sel) pwm8 = 1'b0; else pwm = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    // Each row: high, low, expected high, period, state of the first period
    typedef struct {
        int hi;
        int lo;
        int exp_st;
    } vec_t;

    vec_t vecs[7] = '{
        '{250, 750, 1}, '{500, 500, 2}, '{750, 250, 3},
        '{99, 701, 0}, '{100, 700, 1}, '{300, 500, 2}, '{700, 100, 4}
    };

    initial begin
        int v0;
        int wait_cnt;

        #2 rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pwm = ~pwm;
        end
        check("rst_high", high_cnt, 0);
        check("rst_period", period_cnt, 0);
        check("rst_state", pwm_state, 0);
        check("rst_timeout", timeout, 0);
        check("rst_no_valid", vcnt, 0);

        pwm = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // First rise only opens a measurement
        run_pwm(1'b0, 250, 750, 1);
        check("first_rise_no_valid", vcnt, 0);

        run_pwm(1'b0, 250, 750, 3);
        check("d25_valid_cnt", vcnt, 3);

        // Each row's first period is closed by its second rise
        foreach (vecs[i]) begin
            v0 = vcnt;
            run_pwm(1'b0, vecs[i].hi, vecs[i].lo, 2);
            check($sformatf("vec%0d_valid_cnt", i), vcnt - v0, 2);
            check($sformatf("vec%0d_high", i), last_hi, vecs[i].hi);
            check($sformatf("vec%0d_period", i), last_per, vecs[i].hi + vecs[i].lo);
            check($sformatf("vec%0d_state", i), last_st, vecs[i].exp_st);
        end

        // Stuck high: sync 2 cycles + rise register 1 + 2048 idle cycles
        pwm = 1'b1;
        wait_cnt = 0;
        while (!timeout && wait_cnt < 3000) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("to_latency", wait_cnt, 2051);
        v0 = vcnt;
        repeat (3000 - wait_cnt) @(negedge clk);
        check("to_hi_flag", timeout, 1);
        check("to_hi_state", pwm_state, 4);
        check("to_hi_high", high_cnt, 0);
        check("to_hi_period", period_cnt, 0);
        check("to_no_valid", vcnt - v0, 0);

        pwm = 1'b0;
        repeat (10) @(negedge clk);
        check("to_lo_state", pwm_state, 0);
        check("to_lo_flag", timeout, 1);

        // Resume: first rise clears the flag but reports nothing
        pwm = 1'b1;
        repeat (5) @(negedge clk);
        check("resume_clear", timeout, 0);
        check("resume_no_valid", vcnt - v0, 0);
        repeat (245) @(negedge clk);
        pwm = 1'b0;
        repeat (750) @(negedge clk);
        run_pwm(1'b0, 250, 750, 1);
        check("resume_valid_cnt", vcnt - v0, 1);
        check("resume_high", last_hi, 250);
        check("resume_period", last_per, 1000);
        check("resume_state", last_st, 1);

        // 8-bit counters: 300 high + 100 low saturates both values
        run_pwm(1'b1, 300, 100, 3);
        check("sat_valid_cnt", vcnt8, 2);
        check("sat_high", last_hi8, 255);
        check("sat_period", last_per8, 255);
        check("sat_state", last_st8, 4);
        check("sat_timeout", timeout8, 0);

        // Reset asserted between edges during a high phase
        pwm = 1'b1;
        repeat (50) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_high", high_cnt, 0);
        check("async_period", period_cnt, 0);
        check("async_state", pwm_state, 0);
        check("async_valid", valid, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        v0 = vcnt;
        repeat (300) @(negedge clk);
        check("async_no_stale_valid", vcnt - v0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
